// File: rtl/bcd_highscore_tracker.sv
// High-score register for the BCD counter chain: compares a final score MSD-first, one digit
// per cycle, and keeps it when strictly greater. Optional digit validation: BCD_VALIDATE_EN.
module bcd_highscore_tracker #(
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  game_over,
    input  logic [4*DIGITS-1:0]   score,
    input  logic                  show_high,
    output logic [4*DIGITS-1:0]   highscore,
    output logic                  load_out,
    output logic                  busy,
    output logic                  done,
    output logic                  new_record,
    output logic                  error
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_MSD = IDX_W'(DIGITS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]            state_reg;
    logic [4*DIGITS-1:0]   snapshot_reg;
    logic [4*DIGITS-1:0]   highscore_reg;
    logic [IDX_W-1:0]      index_reg;
    logic                  record_reg;
    logic                  load_reg;

    logic [3:0] snap_digit [DIGITS];
    logic [3:0] high_digit [DIGITS];
    logic [3:0] snap_cur;
    logic [3:0] high_cur;

`ifdef BCD_VALIDATE_EN
    logic                  error_reg;
    logic [DIGITS-1:0]     digit_bad;
    logic                  score_bad;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign snap_digit[gi] = snapshot_reg[4*gi +: 4];
            assign high_digit[gi] = highscore_reg[4*gi +: 4];
`ifdef BCD_VALIDATE_EN
            assign digit_bad[gi]  = (score[4*gi +: 4] > 4'd9);
`endif
        end
    endgenerate

`ifdef BCD_VALIDATE_EN
    assign score_bad = |digit_bad;
`endif

    assign snap_cur = snap_digit[index_reg];
    assign high_cur = high_digit[index_reg];

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg     <= ST_IDLE;
            snapshot_reg  <= '0;
            highscore_reg <= '0;
            index_reg     <= '0;
            record_reg    <= 1'b0;
            load_reg      <= 1'b0;
`ifdef BCD_VALIDATE_EN
            error_reg     <= 1'b0;
`endif
        end else begin
            load_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (game_over) begin
                        snapshot_reg <= score;
                        index_reg    <= IDX_MSD;
                        record_reg   <= 1'b0;
`ifdef BCD_VALIDATE_EN
                        // An invalid score skips the compare so it can never be written back.
                        error_reg    <= score_bad;
                        state_reg    <= score_bad ? ST_DONE : ST_CMP;
`else
                        state_reg    <= ST_CMP;
`endif
                    end else if (show_high) begin
                        load_reg <= 1'b1;
                    end
                end
                ST_CMP: begin
                    if (snap_cur > high_cur) begin
                        state_reg <= ST_WR;
                    end else if (snap_cur < high_cur) begin
                        state_reg <= ST_DONE;
                    end else if (index_reg == '0) begin
                        state_reg <= ST_DONE;
                    end else begin
                        index_reg <= index_reg - 1'b1;
                    end
                end
                ST_WR: begin
                    highscore_reg <= snapshot_reg;
                    record_reg    <= 1'b1;
                    state_reg     <= ST_DONE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign highscore  = highscore_reg;
    assign load_out   = load_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign done       = (state_reg == ST_DONE);
    assign new_record = done & record_reg;
`ifdef BCD_VALIDATE_EN
    assign error      = done & error_reg;
`else
    assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_highscore_tracker.sv
// Directed and randomized checks of bcd_highscore_tracker against a numeric reference model.
module tb_bcd_highscore_tracker;

    localparam int DIGITS = 4;

    logic        clock = 1'b0;
    logic        clear;
    logic        game_over;
    logic        show_high;
    logic [15:0] score;
    logic [15:0] highscore;
    logic        load_out;
    logic        busy;
    logic        done;
    logic        new_record;
    logic        error;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] hs_model = 16'h0000;

    bcd_highscore_tracker #(.DIGITS(DIGITS)) dut (
        .clock      (clock),
        .clear      (clear),
        .game_over  (game_over),
        .score      (score),
        .show_high  (show_high),
        .highscore  (highscore),
        .load_out   (load_out),
        .busy       (busy),
        .done       (done),
        .new_record (new_record),
        .error      (error)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: a packed BCD compare MSD-first equals a plain numeric compare; latency is
    // one edge per leading equal digit plus the deciding digit, plus one for a write.
    function automatic void model(input logic [15:0] hs, input logic [15:0] sc,
                                  output int lat, output bit rec, output bit err);
        int k;
        err = 1'b0;
        rec = 1'b0;
        lat = 0;
`ifdef BCD_VALIDATE_EN
        for (int d = 0; d < DIGITS; d++)
            if (sc[4*d +: 4] > 4'd9) err = 1'b1;
        if (err) return;
`endif
        rec = (sc > hs);
        k = 0;
        while (k < DIGITS && sc[4*(DIGITS-1-k) +: 4] == hs[4*(DIGITS-1-k) +: 4]) k++;
        if (k == DIGITS) lat = DIGITS;
        else             lat = rec ? k + 2 : k + 1;
    endfunction

    task automatic run_compare(input logic [15:0] sc, input bit with_show, input bit noise,
                               input string tag);
        int          lat;
        int          cnt;
        bit          rec;
        bit          err;
        logic [15:0] old;
        model(hs_model, sc, lat, rec, err);
        old       = hs_model;
        game_over = 1'b1;
        show_high = with_show;
        score     = sc;
        tick();
        game_over = 1'b0;
        show_high = 1'b0;
        score     = 16'($urandom);
        chk({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        cnt = 0;
        while (!done && cnt < 20) begin
            chk({tag, " hs_stable"}, 32'(highscore), 32'(old));
            chk({tag, " no_load_busy"}, 32'(load_out), 32'd0);
            if (noise) begin
                game_over = 1'($urandom);
                show_high = 1'($urandom);
            end
            tick();
            cnt++;
        end
        chk({tag, " latency"}, 32'(cnt), 32'(lat));
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " new_record"}, 32'(new_record), 32'(rec));
        chk({tag, " error"}, 32'(error), 32'(err));
        if (rec) hs_model = sc;
        chk({tag, " highscore"}, 32'(highscore), 32'(hs_model));
        // Requests on the edge leaving DONE must be dropped.
        game_over = 1'b1;
        show_high = noise;
        tick();
        game_over = 1'b0;
        show_high = 1'b0;
        chk({tag, " idle_after_done"}, 32'(busy), 32'd0);
        chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, " no_load_after_done"}, 32'(load_out), 32'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear    = 1'b0;
        hs_model = 16'h0000;
        chk("clear highscore", 32'(highscore), 32'h0);
        chk("clear busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] sc;
        int          mode;
        int          d;
        clear     = 1'b1;
        game_over = 1'b0;
        show_high = 1'b0;
        score     = 16'h0000;
        tick();
        tick();
        chk("reset highscore", 32'(highscore), 32'h0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset load_out", 32'(load_out), 32'd0);
        chk("reset new_record", 32'(new_record), 32'd0);
        chk("reset error", 32'(error), 32'd0);
        clear = 1'b0;
        tick();

        run_compare(16'h0099, 1'b0, 1'b0, "first_record");

        // Abort a compare that would otherwise write 0x0999.
        game_over = 1'b1;
        score     = 16'h0999;
        tick();
        game_over = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear    = 1'b0;
        hs_model = 16'h0000;
        chk("abort highscore", 32'(highscore), 32'h0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        tick();
        chk("abort no_late_done", 32'(done), 32'd0);
        chk("abort still_idle", 32'(busy), 32'd0);

        run_compare(16'h0099, 1'b0, 1'b0, "restore_0099");
        run_compare(16'h0120, 1'b0, 1'b0, "greater_digit2");
        run_compare(16'h0120, 1'b0, 1'b0, "tie");
        run_compare(16'h0500, 1'b0, 1'b0, "set_0500");
        run_compare(16'h0499, 1'b0, 1'b1, "less_with_noise");
        run_compare(16'h0777, 1'b1, 1'b0, "go_and_show");

        show_high = 1'b1;
        tick();
        show_high = 1'b0;
        chk("show load_out", 32'(load_out), 32'd1);
        chk("show highscore", 32'(highscore), 32'(hs_model));
        chk("show busy", 32'(busy), 32'd0);
        tick();
        chk("show load_one_cycle", 32'(load_out), 32'd0);
        chk("show highscore_after", 32'(highscore), 32'(hs_model));

        do_clear();
        run_compare(16'h0091, 1'b0, 1'b0, "set_0091");
        run_compare(16'h00A1, 1'b0, 1'b0, "nibble_A");

        for (int it = 0; it < 24; it++) begin
            if (it % 8 == 7) do_clear();
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: sc = hs_model;
                1: for (int k = 0; k < DIGITS; k++) sc[4*k +: 4] = 4'($urandom_range(0, 9));
                2: begin
                    sc = hs_model;
                    d  = int'($urandom_range(0, DIGITS - 1));
                    sc[4*d +: 4] = 4'($urandom_range(0, 9));
                end
                default: sc = 16'($urandom);
            endcase
            run_compare(sc, 1'($urandom), 1'($urandom), $sformatf("rand%0d_%h", it, sc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_highscore_tracker.md
Name: bcd_highscore_tracker

Overview:
Upstream neighbour of the per-digit BCD counter chain. Holds the game high score as DIGITS packed BCD digits and drives the counters' high-score load inputs. At game end it compares the final score against the stored high score, one digit per cycle starting from the most significant digit, and replaces the stored value when the final score is strictly greater. On request it pulses a load strobe so the counter chain shows the high score.

Parameters:
DIGITS, 4, number of BCD digits in the score; digit i occupies bits [4i+3:4i], digit DIGITS-1 is most significant.

Ports:
clock  input  1  single clock; all state changes on its rising edge
clear  input  1  synchronous active-high reset; priority over every other input
game_over  input  1  start-compare request; sampled only in IDLE
score  input  4*DIGITS  packed BCD final score from the counter chain; sampled on the accepting edge only
show_high  input  1  display-high-score request; sampled only in IDLE
highscore  output  4*DIGITS  stored high score, registered; wired to the counters' highscore inputs
load_out  output  1  one-cycle load strobe to the counter chain
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle completion pulse at the end of a compare
new_record  output  1  valid while done=1; 1 means highscore was replaced
error  output  1  valid while done=1; 1 means a non-BCD digit was found (feature-dependent)

Behaviour:
- Reset: clear=1 at an edge -> state IDLE, highscore=0, snapshot=0, index=0, record flag=0, load_out=0, done=0, new_record=0, error=0, busy=0.
- Reset mid-compare: the compare is aborted, no done pulse is produced, and highscore returns to 0.
- States: IDLE, CMP, WR, DONE. All outputs are registered or decoded from the state register; there are no combinational input-to-output paths.
- IDLE, game_over=1: snapshot<=score, index<=DIGITS-1, record flag<=0, error flag<=0, next state CMP.
- IDLE, show_high=1 and game_over=0: load_out=1 for exactly the following cycle; state stays IDLE; highscore is unchanged.
- IDLE, game_over=1 and show_high=1 on the same edge: game_over wins and show_high is dropped.
- Requests arriving while busy=1 are ignored and are not queued.
- CMP, one digit per edge, comparing snapshot[index] with highscore[index] as unsigned 4-bit values:
  - greater -> WR
  - less -> DONE
  - equal and index=0 -> DONE (a tie does not replace)
  - equal and index>0 -> index<=index-1, stay in CMP
- WR: highscore<=snapshot, record flag<=1, next state DONE.
- DONE: done=1, new_record=record flag, error=error flag, all for exactly this one cycle; next state IDLE. A new game_over is accepted on the edge that leaves DONE only in the next IDLE cycle.
- Latency, counted from the accepting edge e0:
  - Best case: reject on the MSD; DONE is entered after e1, so done is high in the cycle after e1.
  - Worst case: greater on the LSD; DONE is entered after e(DIGITS+1).
  - All equal: DONE is entered after eDIGITS.
- highscore only changes in WR or on clear. It is otherwise stable, including while load_out=1.

Optional Feature:
Macro BCD_VALIDATE_EN.
- Defined: on the accepting edge, if any score digit is greater than 9, the block goes directly to DONE with error flag=1 and record flag=0; highscore is never updated from an invalid score.
- Not defined: no digit check is made, error is tied to 0, and digits compare as plain unsigned nibbles.

Test Plan:
- clear=1 mid-CMP with DIGITS=4 and highscore previously 0x0099 -> after the edge: highscore=0x0000, busy=0, no done pulse.
- highscore=0x0099, game_over with score=0x0120 -> digit3 equal at e1, digit2 greater at e2, WR at e3; done=1 and new_record=1 in the cycle after e3; highscore=0x0120.
- highscore=0x0120, score=0x0120 -> 4 CMP edges; done=1, new_record=0; highscore unchanged at 0x0120.
- highscore=0x0500, score=0x0499 -> less on digit2 at e2; done=1, new_record=0; game_over pulses during busy are ignored.
- game_over=1 and show_high=1 on the same IDLE edge -> compare runs and load_out stays 0. Later show_high alone -> load_out=1 for exactly one cycle with highscore stable.
- BCD_VALIDATE_EN defined, score=0x00A1 -> done=1, error=1, new_record=0, highscore unchanged. Without the macro the same stimulus compares digit1 A>previous and sets error=0.
